register_file_2r1w: RTL and testbench

- Parametrised successor to the single-port register array.
- One write port and two independent asynchronous read ports, feeding the K2 datapath's operand A/B buses.
- Adds:
  - configurable read-during-write bypass;
  - optional hardwired-zero register 0;
  - multi-cycle clear sweep with busy handshake, for soft reset of the register bank without asserting rst_n.

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/register_file_2r1w_mux.sv | 16 +
 rtl/register_file_2r1w.sv | 111 +++++++++++
 tb/tb_register_file_2r1w.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the two-read/one-write register file.
package reg_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    function automatic int depth_of(input int addr_bits);
        return 1 << addr_bits;
    endfunction

endpackage

// File: rtl/register_file_2r1w_mux.sv
// Storage read select: picks one register word out of the flattened bank.
module register_file_2r1w_mux
    import reg_file_pkg::*;
#(
    parameter  int bits     = 8,
    parameter  int sel_bits = 2,
    localparam int DEPTH    = depth_of(sel_bits)
) (
    input  logic [DEPTH-1:0][bits-1:0] data_i,
    input  logic [sel_bits-1:0]        sel_i,
    output logic [bits-1:0]            data_o
);

    assign data_o = data_i[sel_i];

endmodule

// File: rtl/register_file_2r1w.sv
// Register bank with one write port, two asynchronous read ports, optional
// write-through bypass, optional hardwired zero register and a clear sweep.
module register_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int bits              = 8,
    parameter int array_select_size = 2,
    parameter bit BYPASS            = 1'b1,
    parameter bit ZERO_REG          = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [array_select_size-1:0] waddr,
    input  logic [bits-1:0]              d,
    input  logic [array_select_size-1:0] raddr_a,
    output logic [bits-1:0]              qa,
    input  logic [array_select_size-1:0] raddr_b,
    output logic [bits-1:0]              qb,
    input  logic                         clr_req,
    output logic                         clr_busy,
    output logic                         wr_ack
);

    localparam int DEPTH = depth_of(array_select_size);
    localparam logic [array_select_size-1:0] LAST_IDX = array_select_size'(DEPTH - 1);

    logic [DEPTH-1:0][bits-1:0]   regs_q, regs_d;
    state_e                       state_q, state_d;
    logic [array_select_size-1:0] cnt_q, cnt_d;
    logic [bits-1:0]              stored_a, stored_b;

    assign wr_ack   = we && (state_q == IDLE) && !(ZERO_REG && (waddr == '0));
    assign clr_busy = (state_q == CLEAR);

    // Writes and the sweep never collide: wr_ack is forced low while clearing.
    always_comb begin
        regs_d  = regs_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (wr_ack) begin
                    regs_d[waddr] = d;
                end
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + array_select_size'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    register_file_2r1w_mux #(
        .bits     (bits),
        .sel_bits (array_select_size)
    ) u_mux_a (
        .data_i (regs_q),
        .sel_i  (raddr_a),
        .data_o (stored_a)
    );

    register_file_2r1w_mux #(
        .bits     (bits),
        .sel_bits (array_select_size)
    ) u_mux_b (
        .data_i (regs_q),
        .sel_i  (raddr_b),
        .data_o (stored_b)
    );

    // Zero register takes priority over bypass so address 0 never leaks d.
    always_comb begin
        if (ZERO_REG && (raddr_a == '0)) begin
            qa = '0;
        end else if (BYPASS && wr_ack && (waddr == raddr_a)) begin
            qa = d;
        end else begin
            qa = stored_a;
        end

        if (ZERO_REG && (raddr_b == '0)) begin
            qb = '0;
        end else if (BYPASS && wr_ack && (waddr == raddr_b)) begin
            qb = d;
        end else begin
            qb = stored_b;
        end
    end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench: default instance (bypass on) plus a ZERO_REG/no-bypass twin.
module tb_register_file_2r1w;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we;
    logic [1:0] waddr;
    logic [7:0] d;
    logic [1:0] raddr_a, raddr_b;
    logic       clr_req;

    logic [7:0] qa, qb, qaZ, qbZ;
    logic       clrBusy, wrAck, clrBusyZ, wrAckZ;

    int nVec  = 0;
    int nMiss = 0;

    always #5 clk = ~clk;

    register_file_2r1w dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .d        (d),
        .raddr_a  (raddr_a),
        .qa       (qa),
        .raddr_b  (raddr_b),
        .qb       (qb),
        .clr_req  (clr_req),
        .clr_busy (clrBusy),
        .wr_ack   (wrAck)
    );

    register_file_2r1w #(
        .bits              (8),
        .array_select_size (2),
        .BYPASS            (1'b0),
        .ZERO_REG          (1'b1)
    ) dutZ (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .d        (d),
        .raddr_a  (raddr_a),
        .qa       (qaZ),
        .raddr_b  (raddr_b),
        .qb       (qbZ),
        .clr_req  (clr_req),
        .clr_busy (clrBusyZ),
        .wr_ack   (wrAckZ)
    );

    typedef struct {
        logic       we;
        logic [1:0] wa;
        logic [7:0] d;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] qa;
        logic [7:0] qb;
        logic       ack;
    } vec_t;

    vec_t tbl[10];

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, settle, then return.
    task automatic applyStimulus(input logic w, input logic [1:0] wa, input logic [7:0] dd,
                                 input logic [1:0] ra, input logic [1:0] rb, input logic c);
        @(negedge clk);
        we      = w;
        waddr   = wa;
        d       = dd;
        raddr_a = ra;
        raddr_b = rb;
        clr_req = c;
        #1;
    endtask

    initial begin
        int busyCycles;
        int budget;

        tbl[0] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 8'h00, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 2'd2, 8'hA5, 2'd0, 2'd1, 8'h00, 8'h00, 1'b1};
        tbl[3] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd2, 8'hA5, 8'hA5, 1'b0};
        tbl[4] = '{1'b1, 2'd1, 8'h3C, 2'd1, 2'd2, 8'h3C, 8'hA5, 1'b1};
        tbl[5] = '{1'b1, 2'd1, 8'h5A, 2'd1, 2'd1, 8'h5A, 8'h5A, 1'b1};
        tbl[6] = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd3, 8'h5A, 8'h00, 1'b0};
        tbl[7] = '{1'b1, 2'd3, 8'hC3, 2'd0, 2'd3, 8'h00, 8'hC3, 1'b1};
        tbl[8] = '{1'b1, 2'd0, 8'h0F, 2'd0, 2'd2, 8'h0F, 8'hA5, 1'b1};
        tbl[9] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 8'h0F, 8'hC3, 1'b0};

        rst_n = 1'b0; we = 1'b0; waddr = '0; d = '0;
        raddr_a = '0; raddr_b = '0; clr_req = 1'b0;
        #22;
        checkOutput("reset busy", {7'd0, clrBusy}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].we, tbl[i].wa, tbl[i].d, tbl[i].ra, tbl[i].rb, 1'b0);
            checkOutput($sformatf("vec%0d qa", i), qa, tbl[i].qa);
            checkOutput($sformatf("vec%0d qb", i), qb, tbl[i].qb);
            checkOutput($sformatf("vec%0d ack", i), {7'd0, wrAck}, {7'd0, tbl[i].ack});
            checkOutput($sformatf("vec%0d busy", i), {7'd0, clrBusy}, 8'h00);
        end

        // Bypass versus stored value on the twin; twin rejected the addr-0 write.
        applyStimulus(1'b1, 2'd1, 8'h3C, 2'd0, 2'd1, 1'b0);
        checkOutput("byp qb", qb, 8'h3C);
        checkOutput("nobyp qb", qbZ, 8'h5A);
        checkOutput("zero qa", qaZ, 8'h00);
        checkOutput("nobyp ack", {7'd0, wrAckZ}, 8'h01);
        applyStimulus(1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 1'b0);
        checkOutput("after qa", qa, 8'h3C);
        checkOutput("after qaZ", qaZ, 8'h3C);
        applyStimulus(1'b1, 2'd0, 8'hFF, 2'd0, 2'd0, 1'b0);
        checkOutput("zw ackZ", {7'd0, wrAckZ}, 8'h00);
        checkOutput("zw qaZ", qaZ, 8'h00);
        checkOutput("zw ack", {7'd0, wrAck}, 8'h01);
        checkOutput("zw qa byp", qa, 8'hFF);
        applyStimulus(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b0);
        checkOutput("z0 qa", qa, 8'hFF);
        checkOutput("z0 qaZ", qaZ, 8'h00);

        // Fill, then a one-cycle clear pulse and a rejected write mid-sweep.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'(i), 8'(8'h11 * (i + 1)), 2'd0, 2'd0, 1'b0);
        end
        applyStimulus(1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 1'b1);
        checkOutput("pre busy", {7'd0, clrBusy}, 8'h00);
        checkOutput("fill qa0", qa, 8'h11);
        checkOutput("fill qb3", qb, 8'h44);
        checkOutput("fill qaZ0", qaZ, 8'h00);
        applyStimulus(1'b1, 2'd3, 8'h77, 2'd3, 2'd0, 1'b0);
        checkOutput("sw0 busy", {7'd0, clrBusy}, 8'h01);
        checkOutput("sw0 ack", {7'd0, wrAck}, 8'h00);
        checkOutput("sw0 qa", qa, 8'h44);
        checkOutput("sw0 qb", qb, 8'h11);
        applyStimulus(1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 1'b0);
        checkOutput("sw1 busy", {7'd0, clrBusy}, 8'h01);
        checkOutput("sw1 qa", qa, 8'h00);
        checkOutput("sw1 qb", qb, 8'h22);
        applyStimulus(1'b0, 2'd0, 8'h00, 2'd1, 2'd3, 1'b0);
        checkOutput("sw2 busy", {7'd0, clrBusy}, 8'h01);
        checkOutput("sw2 qa", qa, 8'h00);
        checkOutput("sw2 qb", qb, 8'h44);
        applyStimulus(1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 1'b0);
        checkOutput("sw3 busy", {7'd0, clrBusyZ}, 8'h01);
        checkOutput("sw3 qa", qa, 8'h00);
        checkOutput("sw3 qb", qb, 8'h44);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 2'd0, 8'h00, 2'(i), 2'(i), 1'b0);
            checkOutput($sformatf("post busy%0d", i), {7'd0, clrBusy}, 8'h00);
            checkOutput($sformatf("post qa%0d", i), qa, 8'h00);
            checkOutput($sformatf("post qbZ%0d", i), qbZ, 8'h00);
        end

        // Write together with clr_req, clr_req held through the sweep.
        applyStimulus(1'b1, 2'd2, 8'h99, 2'd2, 2'd0, 1'b1);
        checkOutput("wc ack", {7'd0, wrAck}, 8'h01);
        checkOutput("wc busy", {7'd0, clrBusy}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 2'd0, 8'h00, 2'd2, 2'd0, 1'b1);
            checkOutput($sformatf("wc busy%0d", i), {7'd0, clrBusy}, 8'h01);
            checkOutput($sformatf("wc qa%0d", i), qa, (i < 3) ? 8'h99 : 8'h00);
        end
        applyStimulus(1'b0, 2'd0, 8'h00, 2'd2, 2'd0, 1'b1);
        checkOutput("gap busy", {7'd0, clrBusy}, 8'h00);
        busyCycles = 0;
        budget     = 0;
        applyStimulus(1'b0, 2'd0, 8'h00, 2'd2, 2'd0, 1'b0);
        while (clrBusy && budget < 10) begin
            busyCycles++;
            budget++;
            applyStimulus(1'b0, 2'd0, 8'h00, 2'd2, 2'd0, 1'b0);
        end
        checkOutput("resweep len", 8'(busyCycles), 8'd4);

        // Reset asserted in the second sweep cycle.
        applyStimulus(1'b1, 2'd3, 8'hDE, 2'd0, 2'd0, 1'b0);
        applyStimulus(1'b1, 2'd1, 8'hAD, 2'd0, 2'd0, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'h00, 2'd3, 2'd1, 1'b1);
        checkOutput("rs qa3", qa, 8'hDE);
        checkOutput("rs qb1", qb, 8'hAD);
        applyStimulus(1'b0, 2'd0, 8'h00, 2'd3, 2'd1, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'h00, 2'd3, 2'd1, 1'b0);
        checkOutput("rs busy", {7'd0, clrBusy}, 8'h01);
        rst_n = 1'b0;
        #1;
        checkOutput("rs busy low", {7'd0, clrBusy}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            raddr_a = 2'(i);
            raddr_b = 2'(3 - i);
            #1;
            checkOutput($sformatf("rs qa%0d", i), qa, 8'h00);
            checkOutput($sformatf("rs qb%0d", 3 - i), qb, 8'h00);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        we      = 1'b1;
        waddr   = 2'd1;
        d       = 8'h6B;
        raddr_a = 2'd3;
        raddr_b = 2'd2;
        clr_req = 1'b0;
        #1;
        checkOutput("rel ack", {7'd0, wrAck}, 8'h01);
        checkOutput("rel qa3", qa, 8'h00);
        applyStimulus(1'b0, 2'd0, 8'h00, 2'd1, 2'd3, 1'b0);
        checkOutput("rel qa1", qa, 8'h6B);
        checkOutput("rel qbZ3", qbZ, 8'h00);
        checkOutput("rel busy", {7'd0, clrBusy}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
